dual_issue_hazard_unit: RTL
===========================

// Module: dual_issue_hazard_unit
// PURPOSE
// - Producer of the E-stage forwarding selects consumed by the per-operand forwarding muxes of the dual-issue (lane A/B) core.
// - Pipelines destination tags (rd, regwrite, load, valid) D->E->M->W internally, using the same stall and flush as the datapath.
// - Compares E-stage sources against the M/W tags of both lanes.
// - Emits 3-bit forward selects, load-use stall and branch flush controls.
// PARAMETERS
// - REG_AW  5   register-address width
// - STAT_W  32  statistics counter width (used only with HAZ_STATS_EN)
// PORTS
// - clk          in   1       core clock
// - reset_n      in   1       async active-low reset
// - ValidA_D     in   1       lane A D-stage slot holds an instruction
// - ValidB_D     in   1       lane B D-stage slot holds an instruction
// - Rs1A_D       in   REG_AW  lane A D-stage source 1
// - Rs2A_D       in   REG_AW  lane A D-stage source 2
// - Rs1B_D       in   REG_AW  lane B D-stage source 1
// - Rs2B_D       in   REG_AW  lane B D-stage source 2
// - RdA_D        in   REG_AW  lane A D-stage destination
// - RdB_D        in   REG_AW  lane B D-stage destination
// - RegWriteA_D  in   1       lane A D-stage writes rd
// - RegWriteB_D  in   1       lane B D-stage writes rd
// - LoadA_D      in   1       lane A D-stage is a load
// - LoadB_D      in   1       lane B D-stage is a load
// - PCSrc_E      in   1       taken branch/jump resolved in E
// - ForwardA1_E  out  3       lane A src1 select
// - ForwardA2_E  out  3       lane A src2 select
// - ForwardB1_E  out  3       lane B src1 select
// - ForwardB2_E  out  3       lane B src2 select
// - Stall_F      out  1       hold PC
// - Stall_D      out  1       hold F/D register
// - Flush_D      out  1       clear F/D register
// - Flush_E      out  1       bubble D/E register
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low.
// - State: E, M and W tag registers per lane.
//   - Each tag is {valid, rd, regwrite, load}.
//   - E-stage registers also hold rs1/rs2 per lane.
//   - Reset clears every valid/regwrite/load bit and zeroes every rs/rd.
//   - After reset, all selects read 3'b000 and all stall/flush outputs read 0 (PCSrc_E low).
// - Select encoding:
//   - 000 = register file
//   - 001 = ResultA_W
//   - 010 = ALUResultA_M
//   - 011 = ResultB_W
//   - 100 = ALUResultB_M
//   - 101..111 are never driven.
//   - Codes 00/01/10 match the existing lane-A 2-bit mux.
// - A stage/lane entry matches an E-stage source when valid && regwrite && rd == rs && rs != 0.
// - Priority for a source: M_B > M_A > W_B > W_A > RF.
//   - M beats W.
//   - Within a stage, lane B is younger, so B beats A.
// - Selects are combinational from registered state only; no input-to-select path exists.
// - Load-use hazard: any valid D source (rs != 0) matches an E-stage entry with load=1 and regwrite=1.
//   - Stall_F = Stall_D = 1.
//   - Flush_E = 1.
//   - The E tags load a bubble (valid=0) and the D bundle is re-presented next cycle.
// - Intra-bundle hazards (B reads A's rd in the same bundle) are excluded by the issue logic and are not detected here.
// - PCSrc_E = 1: Flush_D = 1 and Flush_E = 1.
//   - The E tags load a bubble.
//   - Any concurrent load-use stall is cancelled: Stall_F = Stall_D = 0, because branch wins.
// - Every clock, E->M and M->W advance unconditionally; stalls never freeze M/W.
// - Register-file reads in D see same-cycle W writes because the RF writes on negedge. W-to-D forwarding is therefore not generated.
// - Writes to x0 are tracked but never matched.
// - Reset asserted mid-operation:
//   - All tags are cleared immediately (async).
//   - The first post-reset bundle sees no forwarding.
// CONFIGURATION
// - Macro HAZ_STATS_EN.
// - Defined: adds outputs StallCnt, FwdCnt and FlushCnt (each STAT_W, out).
//   - StallCnt: +1 per load-use stall cycle.
//   - FwdCnt: +1 per cycle with any select != 000.
//   - FlushCnt: +1 per PCSrc_E cycle.
//   - All counters saturate at all-ones and reset to 0.
// - Undefined: no counter ports or logic; behaviour otherwise identical.
// TESTING
// - Reset: hold reset_n=0 for 3 cycles, release -> all selects 000; Stall_F, Stall_D, Flush_D, Flush_E all 0.
// - Lane A ALU hazard:
//   - Stimulus: cycle n lane A writes x5; cycle n+1 lane A reads x5 as rs1.
//   - Response: in E, ForwardA1_E=010. A cycle later, with a filler bundle between, the same read gives 001.
// - Lane B ALU hazard:
//   - Stimulus: cycle n lane B writes x7; next bundle, lane A reads rs2=x7.
//   - Response: ForwardA2_E=100.
// - Double producer:
//   - Stimulus: lanes A and B both write x9; the next bundle reads x9 on B rs1.
//   - Response: ForwardB1_E=100 (B wins).
// - Load-use:
//   - Stimulus: lane A loads x3, then a dependent add on x3 follows immediately.
//   - Response: one cycle of Stall_F=Stall_D=Flush_E=1, then the add's select is 001 in E.
// - Branch beats stall, plus x0:
//   - Stimulus 1: PCSrc_E=1 in the same cycle as a load-use condition. Response: Flush_D=Flush_E=1, Stall_D=0.
//   - Stimulus 2: a write to x0 followed by a read of x0. Response: select 000.

Source files
------------

// File: rtl/dual_issue_hazard_unit.sv
// Dual-issue hazard unit: tracks lane A/B destination tags through E/M/W and produces
// E-stage forward selects, load-use stall and branch flush. Optional counters under HAZ_STATS_EN.
module dual_issue_hazard_unit #(
    parameter int REG_AW = 5
`ifdef HAZ_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ValidA_D,
    input  logic              ValidB_D,
    input  logic [REG_AW-1:0] Rs1A_D,
    input  logic [REG_AW-1:0] Rs2A_D,
    input  logic [REG_AW-1:0] Rs1B_D,
    input  logic [REG_AW-1:0] Rs2B_D,
    input  logic [REG_AW-1:0] RdA_D,
    input  logic [REG_AW-1:0] RdB_D,
    input  logic              RegWriteA_D,
    input  logic              RegWriteB_D,
    input  logic              LoadA_D,
    input  logic              LoadB_D,
    input  logic              PCSrc_E,
    output logic [2:0]        ForwardA1_E,
    output logic [2:0]        ForwardA2_E,
    output logic [2:0]        ForwardB1_E,
    output logic [2:0]        ForwardB2_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Flush_D,
    output logic              Flush_E
`ifdef HAZ_STATS_EN
    ,
    output logic [STAT_W-1:0] StallCnt,
    output logic [STAT_W-1:0] FwdCnt,
    output logic [STAT_W-1:0] FlushCnt
`endif
);

    // _p0 = E stage, _p1 = M stage, _p2 = W stage
    logic              vld_a_p0, rw_a_p0, ld_a_p0;
    logic              vld_b_p0, rw_b_p0, ld_b_p0;
    logic [REG_AW-1:0] rd_a_p0, rs1_a_p0, rs2_a_p0;
    logic [REG_AW-1:0] rd_b_p0, rs1_b_p0, rs2_b_p0;
    logic              vld_a_p1, rw_a_p1, vld_b_p1, rw_b_p1;
    logic [REG_AW-1:0] rd_a_p1, rd_b_p1;
    logic              vld_a_p2, rw_a_p2, vld_b_p2, rw_b_p2;
    logic [REG_AW-1:0] rd_a_p2, rd_b_p2;
    logic              load_use;

    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return v && rw && (rd == rs) && (rs != '0);
    endfunction

    // Younger stage first, and lane B is younger than lane A within a stage.
    function automatic logic [2:0] fwd_sel(input logic mb, input logic ma,
                                           input logic wb, input logic wa);
        if (mb)      return 3'b100;
        else if (ma) return 3'b010;
        else if (wb) return 3'b011;
        else if (wa) return 3'b001;
        else         return 3'b000;
    endfunction

    function automatic logic [2:0] src_sel(input logic en, input logic [REG_AW-1:0] rs,
                                           input logic vb1, input logic wb1, input logic [REG_AW-1:0] db1,
                                           input logic va1, input logic wa1, input logic [REG_AW-1:0] da1,
                                           input logic vb2, input logic wb2, input logic [REG_AW-1:0] db2,
                                           input logic va2, input logic wa2, input logic [REG_AW-1:0] da2);
        if (!en) return 3'b000;
        return fwd_sel(hit(vb1, wb1, db1, rs), hit(va1, wa1, da1, rs),
                       hit(vb2, wb2, db2, rs), hit(va2, wa2, da2, rs));
    endfunction

    function automatic logic lu_hit(input logic va, input logic wa, input logic [REG_AW-1:0] da,
                                    input logic vb, input logic wb, input logic [REG_AW-1:0] db,
                                    input logic [REG_AW-1:0] rs);
        return hit(va, wa, da, rs) || hit(vb, wb, db, rs);
    endfunction

    // E-stage compare against M/W tags
    assign ForwardA1_E = src_sel(vld_a_p0, rs1_a_p0, vld_b_p1, rw_b_p1, rd_b_p1, vld_a_p1, rw_a_p1, rd_a_p1,
                                 vld_b_p2, rw_b_p2, rd_b_p2, vld_a_p2, rw_a_p2, rd_a_p2);
    assign ForwardA2_E = src_sel(vld_a_p0, rs2_a_p0, vld_b_p1, rw_b_p1, rd_b_p1, vld_a_p1, rw_a_p1, rd_a_p1,
                                 vld_b_p2, rw_b_p2, rd_b_p2, vld_a_p2, rw_a_p2, rd_a_p2);
    assign ForwardB1_E = src_sel(vld_b_p0, rs1_b_p0, vld_b_p1, rw_b_p1, rd_b_p1, vld_a_p1, rw_a_p1, rd_a_p1,
                                 vld_b_p2, rw_b_p2, rd_b_p2, vld_a_p2, rw_a_p2, rd_a_p2);
    assign ForwardB2_E = src_sel(vld_b_p0, rs2_b_p0, vld_b_p1, rw_b_p1, rd_b_p1, vld_a_p1, rw_a_p1, rd_a_p1,
                                 vld_b_p2, rw_b_p2, rd_b_p2, vld_a_p2, rw_a_p2, rd_a_p2);

    // D-stage sources against E-stage loads
    assign load_use =
        (ValidA_D && (lu_hit(vld_a_p0, rw_a_p0 && ld_a_p0, rd_a_p0, vld_b_p0, rw_b_p0 && ld_b_p0, rd_b_p0, Rs1A_D) ||
                      lu_hit(vld_a_p0, rw_a_p0 && ld_a_p0, rd_a_p0, vld_b_p0, rw_b_p0 && ld_b_p0, rd_b_p0, Rs2A_D))) ||
        (ValidB_D && (lu_hit(vld_a_p0, rw_a_p0 && ld_a_p0, rd_a_p0, vld_b_p0, rw_b_p0 && ld_b_p0, rd_b_p0, Rs1B_D) ||
                      lu_hit(vld_a_p0, rw_a_p0 && ld_a_p0, rd_a_p0, vld_b_p0, rw_b_p0 && ld_b_p0, rd_b_p0, Rs2B_D)));

    // A taken branch discards the dependent bundle, so it cancels the stall.
    assign Stall_F = load_use && !PCSrc_E;
    assign Stall_D = load_use && !PCSrc_E;
    assign Flush_D = PCSrc_E;
    assign Flush_E = load_use || PCSrc_E;

    // D -> E boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {vld_a_p0, rw_a_p0, ld_a_p0, vld_b_p0, rw_b_p0, ld_b_p0} <= '0;
            {rd_a_p0, rs1_a_p0, rs2_a_p0, rd_b_p0, rs1_b_p0, rs2_b_p0} <= '0;
        end else if (Flush_E) begin
            {vld_a_p0, rw_a_p0, ld_a_p0, vld_b_p0, rw_b_p0, ld_b_p0} <= '0;
            {rd_a_p0, rs1_a_p0, rs2_a_p0, rd_b_p0, rs1_b_p0, rs2_b_p0} <= '0;
        end else begin
            vld_a_p0 <= ValidA_D;    vld_b_p0 <= ValidB_D;
            rw_a_p0  <= RegWriteA_D; rw_b_p0  <= RegWriteB_D;
            ld_a_p0  <= LoadA_D;     ld_b_p0  <= LoadB_D;
            rd_a_p0  <= RdA_D;       rd_b_p0  <= RdB_D;
            rs1_a_p0 <= Rs1A_D;      rs1_b_p0 <= Rs1B_D;
            rs2_a_p0 <= Rs2A_D;      rs2_b_p0 <= Rs2B_D;
        end
    end

    // E -> M -> W boundaries; these never stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {vld_a_p1, rw_a_p1, vld_b_p1, rw_b_p1} <= '0;
            {vld_a_p2, rw_a_p2, vld_b_p2, rw_b_p2} <= '0;
            {rd_a_p1, rd_b_p1, rd_a_p2, rd_b_p2}   <= '0;
        end else begin
            vld_a_p1 <= vld_a_p0; rw_a_p1 <= rw_a_p0; rd_a_p1 <= rd_a_p0;
            vld_b_p1 <= vld_b_p0; rw_b_p1 <= rw_b_p0; rd_b_p1 <= rd_b_p0;
            vld_a_p2 <= vld_a_p1; rw_a_p2 <= rw_a_p1; rd_a_p2 <= rd_a_p1;
            vld_b_p2 <= vld_b_p1; rw_b_p2 <= rw_b_p1; rd_b_p2 <= rd_b_p1;
        end
    end

`ifdef HAZ_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCnt <= '0;
            FwdCnt   <= '0;
            FlushCnt <= '0;
        end else begin
            if (Stall_D) StallCnt <= sat_inc(StallCnt);
            if (|{ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E}) FwdCnt <= sat_inc(FwdCnt);
            if (PCSrc_E) FlushCnt <= sat_inc(FlushCnt);
        end
    end
`endif

endmodule
